ysyx_ifu_icache: RTL

Instruction-fetch unit with a parametrised, direct-mapped, multi-word-line L1 instruction cache. It sits between the PC/next-PC source and the IDU. Instructions are returned over a valid/ready handshake. Misses are refilled one word at a time over a read-address/read-data bus with an `arready` handshake. Compared with the single-word-line fetch unit, this block adds configurable line size and depth, a `fence.i` flush, and optional hit/miss counters.

---
 rtl/ysyx_ifu_icache_pkg.sv | 25 ++
 rtl/ysyx_icache_array.sv | 68 ++++++
 rtl/ysyx_ifu_icache.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_ifu_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_ifu_icache_pkg
// Description : Shared definitions for the IFU instruction cache: FSM state
//               encoding and the derived tag-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_ifu_icache_pkg;

   // Fetch FSM states, explicit 3-bit encoding.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOOKUP  = 3'd1,
      ST_MISS_AR = 3'd2,
      ST_MISS_R  = 3'd3,
      ST_RESP    = 3'd4
   } icache_state_t;

   // Tag width left over after index, word offset and the 2 byte-offset bits.
   function automatic int calc_tag_w(input int addr_w, input int idx_w, input int off_w);
      return addr_w - idx_w - off_w - 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_icache_array.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_icache_array
// Description : Direct-mapped line storage: valid bits, tag RAM and data RAM.
//               Combinational read, synchronous write, flush-all of valid bits.
// Ports       : clk, rst          - clock, sync active-high reset (valid only)
//               flush             - clear every valid bit at the next edge
//               rd_idx/rd_off     - read address; rd_valid/rd_tag/rd_data out
//               data_we, wr_idx, wr_off, wr_data - data word write
//               tag_we, wr_tag, set_valid        - tag write, optional valid set
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_icache_array #(
   parameter int IDX_W  = 4,
   parameter int OFF_W  = 2,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [OFF_W-1:0]  rd_off,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   input  logic              data_we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [OFF_W-1:0]  wr_off,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              tag_we,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic              set_valid
);

   localparam int c_LINES = 1 << IDX_W;
   localparam int c_WORDS = (1 << IDX_W) * (1 << OFF_W);

   logic [c_LINES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag  [c_LINES];
   // Data RAM flattened so that {idx, off} is the word address.
   logic [DATA_W-1:0]  r_data [c_WORDS];

   assign rd_valid = r_valid[rd_idx];
   assign rd_tag   = r_tag[rd_idx];
   assign rd_data  = r_data[{rd_idx, rd_off}];

   // Valid bits are the only reset state; a flush overrides a same-edge set.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= '0;
      end else if (tag_we && set_valid) begin
         r_valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (tag_we) begin
         r_tag[wr_idx] <= wr_tag;
      end
      if (data_we) begin
         r_data[{wr_idx, wr_off}] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_ifu_icache.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_ifu_icache
// Description : Instruction fetch unit with a direct-mapped, multi-word-line
//               L1 I-cache. Misses refill the whole line word by word from
//               word 0 over an AR/R bus. fence.i flush invalidates all lines.
// Ports       : clk, rst (sync, active-high)
//               prev_valid/ready_o/pc        - fetch request in
//               valid_o/next_ready/inst_o/pc_o - instruction out
//               flush_i                      - fence.i, invalidates all lines
//               araddr_o/arvalid_o/arready_i - refill address channel
//               rdata_i/rvalid_i             - refill data channel
//               hit_cnt_o/miss_cnt_o         - only with YSYX_ICACHE_PERF_EN
// Config      : `define YSYX_ICACHE_PERF_EN adds 32-bit hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_ifu_icache
   import ysyx_ifu_icache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 4,
   parameter int OFF_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              prev_valid,
   output logic              ready_o,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              next_ready,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] araddr_o,
   output logic              arvalid_o,
   input  logic              arready_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic              rvalid_i
`ifdef YSYX_ICACHE_PERF_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int TAG_W = calc_tag_w(ADDR_W, IDX_W, OFF_W);

   icache_state_t     r_state;
   logic [ADDR_W-1:0] r_req_pc;
   logic [OFF_W-1:0]  r_cnt;
   logic              r_flush_seen;
   logic [DATA_W-1:0] r_inst;
   logic              r_valid;
   logic              r_arvalid;
   logic [ADDR_W-1:0] r_araddr;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [OFF_W-1:0]  w_off;
   logic [OFF_W-1:0]  w_cnt_next;
   logic              w_rd_valid;
   logic [TAG_W-1:0]  w_rd_tag;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_hit;
   logic              w_refill_we;
   logic              w_last_word;

   // Address fields always come from the latched request.
   assign w_tag      = r_req_pc[ADDR_W-1 -: TAG_W];
   assign w_idx      = r_req_pc[IDX_W+OFF_W+1 -: IDX_W];
   assign w_off      = r_req_pc[OFF_W+1 -: OFF_W];
   assign w_cnt_next = r_cnt + 1'b1;

   assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
   assign w_refill_we = (r_state == ST_MISS_R) && rvalid_i;
   assign w_last_word = (r_cnt == {OFF_W{1'b1}});

   ysyx_icache_array #(
      .IDX_W  (IDX_W),
      .OFF_W  (OFF_W),
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .rd_idx    (w_idx),
      .rd_off    (w_off),
      .rd_valid  (w_rd_valid),
      .rd_tag    (w_rd_tag),
      .rd_data   (w_rd_data),
      .data_we   (w_refill_we),
      .wr_idx    (w_idx),
      .wr_off    (r_cnt),
      .wr_data   (rdata_i),
      .tag_we    (w_refill_we && w_last_word),
      .wr_tag    (w_tag),
      // A flush anywhere in the refill window, including this very cycle,
      // leaves the freshly refilled line invalid.
      .set_valid (!(r_flush_seen || flush_i))
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_req_pc     <= '0;
         r_cnt        <= '0;
         r_flush_seen <= 1'b0;
         r_inst       <= '0;
         r_valid      <= 1'b0;
         r_arvalid    <= 1'b0;
         r_araddr     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (prev_valid) begin
                  r_req_pc <= pc;
                  r_state  <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (w_hit) begin
                  r_inst  <= w_rd_data;
                  r_valid <= 1'b1;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt        <= '0;
                  r_flush_seen <= 1'b0;
                  r_arvalid    <= 1'b1;
                  r_araddr     <= {w_tag, w_idx, {OFF_W{1'b0}}, 2'b00};
                  r_state      <= ST_MISS_AR;
               end
            end
            ST_MISS_AR: begin
               if (flush_i) begin
                  r_flush_seen <= 1'b1;
               end
               if (arready_i) begin
                  r_arvalid <= 1'b0;
                  r_state   <= ST_MISS_R;
               end
            end
            ST_MISS_R: begin
               if (flush_i) begin
                  r_flush_seen <= 1'b1;
               end
               if (rvalid_i) begin
                  if (r_cnt == w_off) begin
                     r_inst <= rdata_i;
                  end
                  if (w_last_word) begin
                     r_valid <= 1'b1;
                     r_state <= ST_RESP;
                  end else begin
                     r_cnt     <= w_cnt_next;
                     r_arvalid <= 1'b1;
                     r_araddr  <= {w_tag, w_idx, w_cnt_next, 2'b00};
                     r_state   <= ST_MISS_AR;
                  end
               end
            end
            ST_RESP: begin
               if (next_ready) begin
                  r_valid <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready_o   = (r_state == ST_IDLE);
   assign valid_o   = r_valid;
   assign inst_o    = r_inst;
   assign pc_o      = r_req_pc;
   assign araddr_o  = r_araddr;
   assign arvalid_o = r_arvalid;

`ifdef YSYX_ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else if (r_state == ST_LOOKUP) begin
         if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire
